// File: rtl/ghostbus_arb_pkg.sv
// Shared types and constants for the ghostbus RAM arbiter.
package ghostbus_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HOST = 2'd1,
    SRC_LOC  = 2'd2
  } src_e;

  typedef enum logic {
    ST_DIRECT  = 1'b0,
    ST_DELAYED = 1'b1
  } arb_state_e;

  localparam int STARVE_CW = 4;
  localparam int STAT_W    = 16;

  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/ghostbus_arb_rdpipe.sv
// Read-response routing: tracks the source of each RAM read for two cycles
// and steers the returning ram_rdata to the host or local response port.
module ghostbus_arb_rdpipe
  import ghostbus_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  src_e          tag_i,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o,
  output logic          loc_rvalid_o,
  output logic [DW-1:0] loc_rdata_o
);

  src_e tag_s1_q, tag_s2_q;

  // Two-stage tag shift register matching issue -> RAM -> data return
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1_q <= SRC_NONE;
      tag_s2_q <= SRC_NONE;
    end else begin
      tag_s1_q <= tag_i;
      tag_s2_q <= tag_s1_q;
    end
  end

  assign host_rvalid_o = (tag_s2_q == SRC_HOST);
  assign loc_rvalid_o  = (tag_s2_q == SRC_LOC);
  assign host_rdata_o  = host_rvalid_o ? ram_rdata_i : '0;
  assign loc_rdata_o   = loc_rvalid_o  ? ram_rdata_i : '0;

endmodule

// File: rtl/ghostbus_ram_arb.sv
// Host/local arbiter for a single-port ghostbus RAM. Host strobes cannot be
// stalled: a one-entry pending register delays a host access by one cycle
// when a starved local request is given a forced slot.
// Optional: define GHOSTBUS_ARB_STATS_EN to add stat_forced / stat_delayed.
module ghostbus_ram_arb
  import ghostbus_arb_pkg::*;
#(
  parameter int AW         = 6,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_we,
  input  logic          host_re,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          loc_req,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [DW-1:0] loc_wdata,
  output logic          loc_gnt,
  output logic [DW-1:0] loc_rdata,
  output logic          loc_rvalid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef GHOSTBUS_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_forced,
  output logic [STAT_W-1:0] stat_delayed
`endif
);

  localparam logic [STARVE_CW-1:0] STARVE_LIM = STARVE_CW'(STARVE_MAX);

  arb_state_e           state_q, state_d;
  logic [STARVE_CW-1:0] starve_q, starve_d, starve_inc;
  logic                 pend_we_q, pend_we_d;
  logic [AW-1:0]        pend_addr_q, pend_addr_d;
  logic [DW-1:0]        pend_wdata_q, pend_wdata_d;
  logic                 ram_en_q, ram_we_q;
  logic [AW-1:0]        ram_addr_q;
  logic [DW-1:0]        ram_wdata_q;
  logic                 iss_en, iss_we, gnt_c, forced, from_pend;
  logic [AW-1:0]        iss_addr;
  logic [DW-1:0]        iss_wdata;
  src_e                 iss_tag;
  logic                 host_stb;

  assign host_stb   = host_we | host_re;
  assign starve_inc = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + STARVE_CW'(1);

  // Next-state, issue selection and grant
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    gnt_c        = 1'b0;
    forced       = 1'b0;
    from_pend    = 1'b0;
    iss_en       = 1'b0;
    iss_we       = 1'b0;
    iss_addr     = ram_addr_q;
    iss_wdata    = ram_wdata_q;
    iss_tag      = SRC_NONE;
    case (state_q)
      ST_DIRECT: begin
        if (host_stb && loc_req && (starve_q >= STARVE_LIM)) begin
          forced       = 1'b1;
          gnt_c        = 1'b1;
          iss_en       = 1'b1;
          iss_we       = loc_we;
          iss_addr     = loc_addr;
          iss_wdata    = loc_wdata;
          iss_tag      = loc_we ? SRC_NONE : SRC_LOC;
          pend_we_d    = host_we;
          pend_addr_d  = host_addr;
          pend_wdata_d = host_wdata;
          starve_d     = '0;
          state_d      = ST_DELAYED;
        end else if (host_stb) begin
          iss_en    = 1'b1;
          iss_we    = host_we;
          iss_addr  = host_addr;
          iss_wdata = host_wdata;
          iss_tag   = host_we ? SRC_NONE : SRC_HOST;
          if (loc_req) starve_d = starve_inc;
        end else begin
          gnt_c    = loc_req;
          starve_d = '0;
          if (loc_req) begin
            iss_en    = 1'b1;
            iss_we    = loc_we;
            iss_addr  = loc_addr;
            iss_wdata = loc_wdata;
            iss_tag   = loc_we ? SRC_NONE : SRC_LOC;
          end
        end
      end
      ST_DELAYED: begin
        from_pend = 1'b1;
        iss_en    = 1'b1;
        iss_we    = pend_we_q;
        iss_addr  = pend_addr_q;
        iss_wdata = pend_wdata_q;
        iss_tag   = pend_we_q ? SRC_NONE : SRC_HOST;
        if (host_stb) begin
          pend_we_d    = host_we;
          pend_addr_d  = host_addr;
          pend_wdata_d = host_wdata;
        end else begin
          state_d = ST_DIRECT;
        end
        if (loc_req) starve_d = starve_inc;
      end
      default: state_d = ST_DIRECT;
    endcase
  end

  // State, pending entry and registered RAM interface
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_DIRECT;
      starve_q     <= '0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      ram_en_q     <= iss_en;
      ram_we_q     <= iss_en & iss_we;
      ram_addr_q   <= iss_addr;
      ram_wdata_q  <= iss_wdata;
    end
  end

  assign loc_gnt   = gnt_c & ~rst;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  ghostbus_arb_rdpipe #(.DW(DW)) u_rdpipe (
    .clk          (clk),
    .rst          (rst),
    .tag_i        (iss_tag),
    .ram_rdata_i  (ram_rdata),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .loc_rvalid_o (loc_rvalid),
    .loc_rdata_o  (loc_rdata)
  );

`ifdef GHOSTBUS_ARB_STATS_EN
  logic [STAT_W-1:0] stat_forced_q, stat_delayed_q;

  // Saturating event counters for forced slots and delayed host issues
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_forced_q  <= '0;
      stat_delayed_q <= '0;
    end else begin
      if (forced)    stat_forced_q  <= stat_sat_inc(stat_forced_q);
      if (from_pend) stat_delayed_q <= stat_sat_inc(stat_delayed_q);
    end
  end

  assign stat_forced  = stat_forced_q;
  assign stat_delayed = stat_delayed_q;
`else
  logic unused_stats;
  assign unused_stats = forced ^ from_pend;
`endif

endmodule

// File: tb/tb_ghostbus_ram_arb.sv
// Directed bench for ghostbus_ram_arb with a behavioural 1-cycle-latency RAM.
module tb_ghostbus_ram_arb;
  import ghostbus_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_we, host_re;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          loc_req, loc_we;
  logic [AW-1:0] loc_addr;
  logic [DW-1:0] loc_wdata;
  logic          loc_gnt;
  logic [DW-1:0] loc_rdata;
  logic          loc_rvalid;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef GHOSTBUS_ARB_STATS_EN
  logic [STAT_W-1:0] stat_forced, stat_delayed;
`endif

  ghostbus_ram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .loc_req    (loc_req),
    .loc_we     (loc_we),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .loc_gnt    (loc_gnt),
    .loc_rdata  (loc_rdata),
    .loc_rvalid (loc_rvalid),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef GHOSTBUS_ARB_STATS_EN
    ,
    .stat_forced (stat_forced),
    .stat_delayed(stat_delayed)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:63];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  initial begin
    ram_rdata  = '0;
    mem[6'h3F] = 8'h5C;
    rst = 1'b1;
    host_addr = '0; host_wdata = '0; host_we = 1'b0; host_re = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    step();
    step();

    // Reset state
    loc_req = 1'b1;
    @(negedge clk);
    chk("rst_gnt", loc_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_loc_rvalid", loc_rvalid, 0);
    step();
    loc_req = 1'b0;
    rst = 1'b0;
    step();

    // Host write 0x10 <= 0xA5 then host read 0x10
    host_we = 1'b1; host_addr = 6'h10; host_wdata = 8'hA5;
    step();
    host_we = 1'b0;
    chk("hw_ram_en", ram_en, 1);
    chk("hw_ram_we", ram_we, 1);
    chk("hw_ram_addr", ram_addr, 6'h10);
    chk("hw_ram_wdata", ram_wdata, 8'hA5);
    host_re = 1'b1; host_addr = 6'h10;
    step();
    host_re = 1'b0;
    chk("hr_ram_en", ram_en, 1);
    chk("hr_ram_we", ram_we, 0);
    chk("hr_ram_addr", ram_addr, 6'h10);
    chk("hr_rvalid_early", host_rvalid, 0);
    step();
    chk("hr_idle_en", ram_en, 0);
    chk("hr_idle_addr_hold", ram_addr, 6'h10);
    chk("hr_rvalid", host_rvalid, 1);
    chk("hr_rdata", host_rdata, 8'hA5);
    chk("hr_loc_rvalid", loc_rvalid, 0);
    step();
    chk("hr_rvalid_pulse", host_rvalid, 0);

    // Local read 0x3F, no host traffic
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 6'h3F;
    @(negedge clk);
    chk("lr_gnt", loc_gnt, 1);
    step();
    loc_req = 1'b0;
    chk("lr_ram_en", ram_en, 1);
    chk("lr_ram_addr", ram_addr, 6'h3F);
    chk("lr_ram_we", ram_we, 0);
    step();
    chk("lr_rvalid", loc_rvalid, 1);
    chk("lr_rdata", loc_rdata, 8'h5C);
    chk("lr_host_rvalid", host_rvalid, 0);
    step();

    // Host strobes for 10 cycles with a permanent local write request
    for (int i = 1; i <= 12; i++) begin
      host_we    = (i <= 10);
      host_addr  = 6'(8 + i);
      host_wdata = 8'(8'hB0 + i);
      loc_req    = 1'b1; loc_we = 1'b1; loc_addr = 6'h30; loc_wdata = 8'h77;
      @(negedge clk);
      chk($sformatf("st_gnt_c%0d", i), loc_gnt, (i == 5 || i == 12) ? 1 : 0);
      step();
      if (i == 5 || i == 12) begin
        exp_addr = 6'h30; exp_wdata = 8'h77;
      end else if (i <= 4) begin
        exp_addr = 6'(8 + i); exp_wdata = 8'(8'hB0 + i);
      end else begin
        exp_addr = 6'(8 + i - 1); exp_wdata = 8'(8'hB0 + i - 1);
      end
      chk($sformatf("st_en_c%0d", i), ram_en, 1);
      chk($sformatf("st_we_c%0d", i), ram_we, 1);
      chk($sformatf("st_addr_c%0d", i), ram_addr, exp_addr);
      chk($sformatf("st_wdata_c%0d", i), ram_wdata, exp_wdata);
    end
    host_we = 1'b0; loc_req = 1'b0;
    step();
    chk("st_idle_en", ram_en, 0);
    chk("st_idle_addr_hold", ram_addr, 6'h30);
`ifdef GHOSTBUS_ARB_STATS_EN
    chk("stat_forced", stat_forced, 1);
    chk("stat_delayed", stat_delayed, 6);
`endif

    // Simultaneous host write 0x20 and local read 0x20
    host_we = 1'b1; host_addr = 6'h20; host_wdata = 8'h11;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 6'h20;
    @(negedge clk);
    chk("sim_gnt_blocked", loc_gnt, 0);
    step();
    host_we = 1'b0;
    chk("sim_host_first_we", ram_we, 1);
    chk("sim_host_first_addr", ram_addr, 6'h20);
    @(negedge clk);
    chk("sim_gnt_next", loc_gnt, 1);
    step();
    loc_req = 1'b0;
    chk("sim_loc_en", ram_en, 1);
    chk("sim_loc_we", ram_we, 0);
    step();
    chk("sim_loc_rvalid", loc_rvalid, 1);
    chk("sim_loc_rdata", loc_rdata, 8'h11);
    step();

    // Reset one cycle after a host read issue
    host_re = 1'b1; host_addr = 6'h10;
    step();
    host_re = 1'b0;
    chk("rr_issued", ram_en, 1);
    rst = 1'b1;
    step();
    chk("rr_no_rvalid", host_rvalid, 0);
    chk("rr_no_rdata", host_rdata, 0);
    chk("rr_ram_en", ram_en, 0);
    chk("rr_ram_addr", ram_addr, 0);
    chk("rr_loc_rvalid", loc_rvalid, 0);
`ifdef GHOSTBUS_ARB_STATS_EN
    chk("rr_stat_forced", stat_forced, 0);
    chk("rr_stat_delayed", stat_delayed, 0);
`endif
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 6'h3F;
    @(negedge clk);
    chk("rr_gnt_in_rst", loc_gnt, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_post_gnt", loc_gnt, 1);
    step();
    loc_req = 1'b0;
    chk("rr_post_addr", ram_addr, 6'h3F);
    step();
    chk("rr_post_rvalid", loc_rvalid, 1);
    chk("rr_post_rdata", loc_rdata, 8'h5C);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
